// File: rtl/sha256_msg_pad_pkg.sv
// Shared SHA-256 message-path definitions: block geometry, padding constants,
// the padder state encoding and a byte-lane helper.
// The schedule and compression blocks import this package as well.
package sha256_msg_pad_pkg;

  // Block geometry
  localparam int SHA256_BLOCK_W      = 512;
  localparam int SHA256_LEN_FIELD_W  = 64;
  localparam int SHA256_BLOCK_BYTES  = SHA256_BLOCK_W / 8;

  // First byte index of the length field (56)
  localparam int SHA256_LEN_POS      = SHA256_BLOCK_BYTES - (SHA256_LEN_FIELD_W / 8);

  // Padding byte that terminates the message
  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

  // Padder states:
  //   FILL  - taking message bytes
  //   PAD80 - writing the 0x80 marker
  //   ZERO  - zero fill
  //   LEN   - writing the length field
  //   EMIT  - presenting a block
  typedef enum logic [2:0] {
    FILL  = 3'd0,
    PAD80 = 3'd1,
    ZERO  = 3'd2,
    LEN   = 3'd3,
    EMIT  = 3'd4
  } padState_e;

  // Byte 0 of a block lives in the top byte lane, so lane N starts at bit 504-8N.
  function automatic logic [8:0] byteLsb(input logic [5:0] lane);
    return 9'(SHA256_BLOCK_W - 8) - {lane, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder.
// Packs an incoming byte stream into 512-bit blocks.
// Appends the 0x80 marker, the zero fill and the 64-bit big-endian bit length,
// spilling into an extra block when the length field no longer fits.
module sha256_msg_pad
  import sha256_msg_pad_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [SHA256_BLOCK_W-1:0] blk_data,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic                      blk_last,
  output logic                      busy
);

  padState_e                 r_state;
  padState_e                 r_retState;
  logic [6:0]                r_idx;
  logic [LEN_W-1:0]          r_len;
  logic [SHA256_BLOCK_W-1:0] r_blkData;
  logic                      r_blkValid;
  logic                      r_blkLast;
  logic                      r_busy;

  logic                          w_accept;
  logic [6:0]                    w_nextIdx;
  logic [8:0]                    w_laneLsb;
  logic [SHA256_LEN_FIELD_W-1:0] w_lenField;

  // Bytes are only taken while filling; reset forces in_ready low immediately.
  assign in_ready  = (r_state == FILL) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_nextIdx = r_idx + 7'd1;
  assign w_laneLsb = byteLsb(r_idx[5:0]);

  assign blk_data  = r_blkData;
  assign blk_valid = r_blkValid;
  assign blk_last  = r_blkLast;
  assign busy      = r_busy;

  // Zero-extend the running bit count into the 64-bit length field.
  always_comb begin
    w_lenField              = '0;
    w_lenField[LEN_W-1:0]   = r_len;
  end

  // Padder state machine.
  // The block buffer doubles as the registered output, so blk_data is stable in EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FILL;
      r_retState <= FILL;
      r_idx      <= '0;
      r_len      <= '0;
      r_blkData  <= '0;
      r_blkValid <= 1'b0;
      r_blkLast  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            r_blkData[w_laneLsb +: 8] <= in_data;
            r_len                     <= r_len + LEN_W'(8);
            r_busy                    <= 1'b1;
            if (r_idx == 7'(SHA256_BLOCK_BYTES - 1)) begin
              // Block full: ship it, then resume padding or filling.
              r_idx      <= 7'(SHA256_BLOCK_BYTES);
              r_blkValid <= 1'b1;
              r_state    <= EMIT;
              r_retState <= in_last ? PAD80 : FILL;
            end else begin
              r_idx <= w_nextIdx;
              if (in_last) begin
                r_state <= PAD80;
              end
            end
          end
        end

        PAD80: begin
          r_blkData[w_laneLsb +: 8] <= SHA256_PAD_BYTE;
          r_idx                     <= w_nextIdx;
          if (w_nextIdx == 7'(SHA256_BLOCK_BYTES)) begin
            // Marker took the last lane: the length goes into a fresh block.
            r_blkValid <= 1'b1;
            r_state    <= EMIT;
            r_retState <= ZERO;
          end else begin
            // Whether the length still fits is decided in ZERO: it stops at lane 56
            // when it starts below it, otherwise it runs on to the end of the block.
            r_state <= ZERO;
          end
        end

        ZERO: begin
          if (r_idx == 7'(SHA256_LEN_POS)) begin
            r_state <= LEN;
          end else if (r_idx == 7'(SHA256_BLOCK_BYTES)) begin
            r_blkValid <= 1'b1;
            r_state    <= EMIT;
            r_retState <= ZERO;
          end else begin
            r_blkData[w_laneLsb +: 8] <= 8'h00;
            r_idx                     <= w_nextIdx;
          end
        end

        LEN: begin
          r_blkData[SHA256_LEN_FIELD_W-1:0] <= w_lenField;
          r_idx                             <= 7'(SHA256_BLOCK_BYTES);
          r_blkLast                         <= 1'b1;
          r_blkValid                        <= 1'b1;
          r_state                           <= EMIT;
        end

        EMIT: begin
          if (blk_ready) begin
            r_blkValid <= 1'b0;
            r_blkData  <= '0;
            r_idx      <= '0;
            if (r_blkLast) begin
              r_blkLast <= 1'b0;
              r_len     <= '0;
              r_busy    <= 1'b0;
              r_state   <= FILL;
            end else begin
              r_state <= r_retState;
            end
          end
        end

        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Testbench for sha256_msg_pad.
// Expected blocks come from a byte-queue model of FIPS 180-4 padding.
module tb_sha256_msg_pad;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_last;
  logic         busy;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  sha256_msg_pad #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_last  (blk_last),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   curMsg[$];
  logic [7:0]   expBytes[$];
  int           rxBlocks;
  logic [511:0] rxFirstBlock;
  logic [63:0]  rxLastLen;

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 416'h0, 64'h18};

  typedef struct {
    int          msgLen;
    logic [7:0]  fill;
    int          expBlocks;
    logic [63:0] expLen;
  } vec_t;

  vec_t vecs[7];

  task automatic checkWide(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkNum(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected completion", name);
  endtask

  // Model: message, 0x80, zeros up to 56 mod 64, then 64-bit big-endian bit count
  function automatic void buildExpected();
    logic [63:0] bits;
    expBytes = curMsg;
    expBytes.push_back(8'h80);
    while ((expBytes.size() % 64) != 56) expBytes.push_back(8'h00);
    bits = 64'(curMsg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) expBytes.push_back(bits[8*k +: 8]);
  endfunction

  // Drive curMsg into the byte port, optionally with random idle cycles
  task automatic applyStimulus(input int gapPct);
    int i = 0;
    int guard = 0;
    bit pending = 1'b0;
    while (i < curMsg.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (pending) i++;
      pending = 1'b0;
      if (i < curMsg.size()) begin
        if (int'($urandom_range(0, 99)) < gapPct) begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = curMsg[i];
          in_last  = (i == curMsg.size() - 1);
        end
        pending = in_valid && in_ready;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (i < curMsg.size()) timeoutFail("byte acceptance");
  endtask

  // Collect blocks, holding blk_ready low for holdCycles, and compare with the model
  task automatic checkOutput(input int holdCycles);
    int nExp = expBytes.size() / 64;
    int waitCnt;
    logic [511:0] expBlk;
    logic [511:0] firstData;
    logic firstLast;
    bit stable;
    bit inReadyLow;
    rxBlocks = 0;
    for (int b = 0; b < nExp; b++) begin
      waitCnt = 0;
      while (blk_valid !== 1'b1 && waitCnt < 2000) begin
        @(negedge clk);
        waitCnt++;
      end
      if (blk_valid !== 1'b1) begin
        timeoutFail("blk_valid wait");
        return;
      end
      for (int j = 0; j < 64; j++) expBlk[511-8*j -: 8] = expBytes[64*b + j];
      firstData  = blk_data;
      firstLast  = blk_last;
      stable     = 1'b1;
      inReadyLow = (in_ready === 1'b0);
      for (int h = 0; h < holdCycles; h++) begin
        @(negedge clk);
        if (blk_data !== firstData || blk_last !== firstLast || blk_valid !== 1'b1) stable = 1'b0;
        if (in_ready !== 1'b0) inReadyLow = 1'b0;
      end
      checkBit("block stable while stalled", stable, 1'b1);
      checkBit("in_ready low in emit", inReadyLow, 1'b1);
      checkBit("busy during emit", busy, 1'b1);
      checkWide("block data", blk_data, expBlk);
      checkBit("block last", blk_last, (b == nExp - 1));
      if (b == 0) rxFirstBlock = blk_data;
      rxLastLen = blk_data[63:0];
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b0;
      rxBlocks++;
    end
    // No further block may appear once the message is finished
    for (int w = 0; w < 80; w++) begin
      @(negedge clk);
      if (blk_valid === 1'b1) begin
        checkBit("extra block", blk_valid, 1'b0);
        break;
      end
    end
    checkBit("busy after message", busy, 1'b0);
  endtask

  task automatic runMessage(input int gapPct, input int holdCycles);
    buildExpected();
    fork
      applyStimulus(gapPct);
      checkOutput(holdCycles);
    join
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b0;

    vecs[0] = '{55,  8'h41, 1, 64'h1B8};
    vecs[1] = '{56,  8'h41, 2, 64'h1C0};
    vecs[2] = '{64,  8'h00, 2, 64'h200};
    vecs[3] = '{1,   8'hFF, 1, 64'h8};
    vecs[4] = '{63,  8'h5A, 2, 64'h1F8};
    vecs[5] = '{119, 8'h11, 2, 64'h3B8};
    vecs[6] = '{120, 8'h22, 3, 64'h3C0};

    // Reset state
    repeat (3) @(negedge clk);
    checkWide("reset blk_data", blk_data, 512'h0);
    checkBit("reset blk_valid", blk_valid, 1'b0);
    checkBit("reset blk_last", blk_last, 1'b0);
    checkBit("reset busy", busy, 1'b0);
    checkBit("in_ready during reset", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkBit("in_ready after reset", in_ready, 1'b1);

    // "abc" single block
    curMsg = {8'h61, 8'h62, 8'h63};
    runMessage(0, 0);
    checkWide("abc block", rxFirstBlock, ABC_BLOCK);
    checkNum("abc block count", 64'(rxBlocks), 64'd1);

    // Boundary lengths from the table
    foreach (vecs[v]) begin
      curMsg.delete();
      for (int k = 0; k < vecs[v].msgLen; k++) curMsg.push_back(vecs[v].fill);
      runMessage(0, 1);
      checkNum($sformatf("len %0d block count", vecs[v].msgLen), 64'(rxBlocks), 64'(vecs[v].expBlocks));
      checkNum($sformatf("len %0d length field", vecs[v].msgLen), rxLastLen, vecs[v].expLen);
    end

    // "abc" with input gaps and a long consumer stall
    curMsg = {8'h61, 8'h62, 8'h63};
    runMessage(40, 20);
    checkWide("abc stalled block", rxFirstBlock, ABC_BLOCK);

    // Reset in the middle of a message, then "abc"
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(k + 1);
      in_last  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkBit("busy mid-message", busy, 1'b1);
    rst = 1'b1;
    #1;
    checkBit("abort blk_valid", blk_valid, 1'b0);
    checkBit("abort busy", busy, 1'b0);
    checkWide("abort blk_data", blk_data, 512'h0);
    @(negedge clk);
    rst = 1'b0;
    curMsg = {8'h61, 8'h62, 8'h63};
    runMessage(0, 0);
    checkWide("abc after abort", rxFirstBlock, ABC_BLOCK);
    checkNum("abc after abort count", 64'(rxBlocks), 64'd1);

    // Random messages against the model
    for (int r = 0; r < 12; r++) begin
      curMsg.delete();
      for (int k = 0; k < int'($urandom_range(1, 150)); k++) curMsg.push_back(8'($urandom));
      runMessage(int'($urandom_range(0, 60)), int'($urandom_range(0, 5)));
      checkNum("random length field", rxLastLen, 64'(curMsg.size()) * 64'd8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
